spi_master_cfg: RTL
===================

// Module: spi_master_cfg
// PURPOSE
//   Parametrised SPI master, successor to the fixed single-mode transmitter: full-duplex
//   (SDO + SDI), runtime CPOL/CPHA, configurable word width and SCLK divider, NUM_CS
//   active-low chip selects, optional LSB-first. Sits between an on-chip controller
//   (start/done handshake) and off-chip test peripherals on the SoC test setup.
// PARAMETERS
//   DATA_W    16  bits per transfer (>=2)
//   CLK_DIV   4   clk_i cycles per SCLK half-period (>=1)
//   NUM_CS    2   number of chip-select outputs (>=1)
//   MSB_FIRST 1   1: bit DATA_W-1 first on wire; 0: bit 0 first
// PORTS
//   clk_i     in   1                  system clock
//   rst_ni    in   1                  async active-low reset
//   start     in   1                  request transfer; accepted only while busy=0
//   cpol_i    in   1                  SCLK idle level, latched at accept
//   cpha_i    in   1                  0: sample leading edge; 1: sample trailing, latched at accept
//   cs_sel_i  in   $clog2(NUM_CS)|1   target slave index, latched at accept
//   tx_data_i in   DATA_W             word to send, latched at accept
//   rx_data_o out  DATA_W             word received, updated in done cycle, held until next done
//   busy      out  1                  transfer in progress
//   done      out  1                  one-cycle pulse at transfer end
//   spi_sclk  out  1                  serial clock
//   spi_sdo   out  1                  serial data out (MOSI)
//   spi_sdi   in   1                  serial data in (MISO)
//   spi_cs    out  NUM_CS             chip selects, active low
// BEHAVIOUR
//   Reset (async, rst_ni=0): state IDLE; spi_sclk=0, spi_sdo=0, spi_cs=all 1, busy=0,
//     done=0, rx_data_o=0, latched cpol=0. Reset mid-transfer aborts immediately; no done.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. Single divider counter counts CLK_DIV.
//   IDLE: sclk=latched cpol. start=1 at edge N latches config+tx, -> SETUP.
//   SETUP (from N+1): busy=1, spi_cs[cs_sel]=0, sclk at cpol; CPHA=0 drives first bit on
//     spi_sdo now. After CLK_DIV cycles -> SHIFT.
//   SHIFT: sclk toggles every CLK_DIV cycles; edge k (k=1..2*DATA_W) at N+1+k*CLK_DIV.
//     CPHA=0: odd edges sample spi_sdi, even edges (k<2*DATA_W) shift next bit to sdo.
//     CPHA=1: odd edges drive next bit on sdo, even edges sample spi_sdi.
//     After edge 2*DATA_W sclk is back at cpol; wait CLK_DIV more cycles -> HOLD.
//   HOLD (cycle N+1+CLK_DIV*(2*DATA_W+1)): spi_cs all 1, done=1, rx_data_o updated,
//     busy=0 from next cycle, -> IDLE. start sampled next cycle is accepted (back-to-back).
//   Latency start-accept to done = 1+CLK_DIV*(2*DATA_W+1) cycles (133 at defaults).
//   start while busy=1: ignored, not queued. Input changes after accept: no effect.
//   cs_sel_i >= NUM_CS: transfer runs with timing unchanged, all spi_cs stay high.
//   Bit order: MSB_FIRST selects shift direction for both tx and rx registers.
//   spi_sdo outside SETUP/SHIFT: 0. All outputs registered (no comb paths to pins).
// TESTING
//   Reset: hold rst_ni=0 -> sclk=0, sdo=0, spi_cs=2'b11, busy=0, done=0, rx_data_o=0.
//   Mode0, tx=16'hA5C3, cs_sel=1, sdi loopback from sdo -> spi_cs=2'b01 during xfer,
//     rx_data_o=16'hA5C3, done exactly 133 cycles after accept, 16 rising edges.
//   Mode3 (cpol=1,cpha=1), tx=16'h0001, slave model returns 16'hBEEF -> sclk idles 1,
//     rx_data_o=16'hBEEF, sdo changes only on falling edges.
//   start re-pulsed mid-transfer and held high after done -> first xfer unaffected,
//     second xfer begins the cycle after busy falls, two done pulses total.
//   cs_sel=3 (NUM_CS=2) -> spi_cs stays 2'b11, done still at 133 cycles.
//   rst_ni low at edge 10 of SHIFT -> cs=all 1, sclk=0, busy=0 at once; no done pulse.

Source files
------------

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with runtime CPOL/CPHA, one chip select per slave and a
// single divider counter that sets both the setup time and the SCLK half-period.
module spi_master_cfg #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 2,
  parameter int MSB_FIRST = 1,
  // one spare bit so that out-of-range slave indices can be expressed
  localparam int CS_W     = $clog2(NUM_CS) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_sdo,
  input  logic              spi_sdi,
  output logic [NUM_CS-1:0] spi_cs
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam int EDG_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDG_W-1:0] EDG_LAST  = EDG_W'(2 * DATA_W);
  localparam logic [EDG_W-1:0] EDG_PEN   = EDG_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [EDG_W-1:0]  edg, edg_n;
  logic              cpol_q, cpol_n, cpha_q, cpha_n;
  logic [DATA_W-1:0] tx_sh, tx_n, rx_sh, rx_n, rxd_n;
  logic              busy_n, done_n, sclk_n, sdo_n, do_edge;
  logic [NUM_CS-1:0] cs_n;

  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    edg_n   = edg;
    cpol_n  = cpol_q;
    cpha_n  = cpha_q;
    tx_n    = tx_sh;
    rx_n    = rx_sh;
    rxd_n   = rx_data_o;
    busy_n  = busy;
    done_n  = 1'b0;
    sclk_n  = spi_sclk;
    sdo_n   = spi_sdo;
    cs_n    = spi_cs;
    do_edge = 1'b0;
    case (state)
      IDLE: begin
        sdo_n  = 1'b0;
        sclk_n = cpol_q;
        if (start) begin
          state_n = SETUP;
          cpol_n  = cpol_i;
          cpha_n  = cpha_i;
          tx_n    = tx_data_i;
          rx_n    = '0;
          cnt_n   = '0;
          edg_n   = '0;
          busy_n  = 1'b1;
          sclk_n  = cpol_i;
          sdo_n   = cpha_i ? 1'b0 : out_bit(tx_data_i);
          cs_n    = '1;
          for (int unsigned i = 0; i < NUM_CS; i++)
            if (cs_sel_i == CS_W'(i)) cs_n[i] = 1'b0;
        end
      end
      // SETUP runs one cycle longer than a half-period so edge 1 lands after the accept cycle
      SETUP: begin
        if (cnt == CNT_SETUP) begin
          do_edge = 1'b1;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CNT_HALF) begin
          if (edg == EDG_LAST) begin
            state_n = HOLD;
            done_n  = 1'b1;
            cs_n    = '1;
            sdo_n   = 1'b0;
            rxd_n   = rx_sh;
            cnt_n   = '0;
          end else begin
            do_edge = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    if (do_edge) begin
      cnt_n  = '0;
      edg_n  = edg + 1'b1;
      sclk_n = ~spi_sclk;
      // edge number edg+1 is odd when edg[0]==0; the sampling edge parity follows CPHA
      if (edg[0] == cpha_q) begin
        rx_n = shift_in(rx_sh, spi_sdi);
      end else if (cpha_q) begin
        sdo_n = out_bit(tx_sh);
        tx_n  = shift_in(tx_sh, 1'b0);
      end else if (edg != EDG_PEN) begin
        tx_n  = shift_in(tx_sh, 1'b0);
        sdo_n = out_bit(tx_n);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      edg       <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_data_o <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_sdo   <= 1'b0;
      spi_cs    <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      edg       <= edg_n;
      cpol_q    <= cpol_n;
      cpha_q    <= cpha_n;
      tx_sh     <= tx_n;
      rx_sh     <= rx_n;
      rx_data_o <= rxd_n;
      busy      <= busy_n;
      done      <= done_n;
      spi_sclk  <= sclk_n;
      spi_sdo   <= sdo_n;
      spi_cs    <= cs_n;
    end
  end

endmodule
